// File: rtl/cei_mochila_pkg.sv
// System-level sizing constants for the cei_mochila SoC.
package cei_mochila_pkg;

  localparam int unsigned PERIPH_NMASTERS        = 2;
  localparam int unsigned PERIPH_MAX_OUTSTANDING = 2;

endpackage

// File: rtl/obi_pkg.sv
// OBI request/response bundles shared by all masters and slaves of the subsystem.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/periph_arb_idx_fifo.sv
// In-order FIFO of granted master indices; head names the owner of the next rvalid.
module periph_arb_idx_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 1,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been pushed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/periph_obi_arbiter.sv
// Round-robin OBI arbiter in front of the peripheral subsystem slave port,
// with request locking until grant and in-order routing of responses.
module periph_obi_arbiter
  import obi_pkg::*;
  import cei_mochila_pkg::*;
#(
  parameter int unsigned NumMasters     = PERIPH_NMASTERS,
  parameter int unsigned MaxOutstanding = PERIPH_MAX_OUTSTANDING,
  localparam int unsigned IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1,
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  obi_req_t  [NumMasters-1:0] master_req_i,
  output obi_resp_t [NumMasters-1:0] master_resp_o,
  output obi_req_t                   slave_req_o,
  input  obi_resp_t                  slave_resp_i,
  output logic [CntW-1:0]            outstanding_o
);

  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] locked_idx_q, locked_idx_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] rr_sel, cand, sel;
  logic            found;
  logic            issue, grant, pop;
  logic            fifo_full, fifo_empty;
  logic [IdxW-1:0] fifo_head;

  always_comb begin
    rr_sel = rr_ptr_q;
    cand   = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < NumMasters; k++) begin
      cand = IdxW'((32'(rr_ptr_q) + k) % NumMasters);
      if (!found && master_req_i[cand].req) begin
        rr_sel = cand;
        found  = 1'b1;
      end
    end
  end

  // A locked master keeps the port even if it drops req; the slave then sees req=0.
  assign sel   = lock_q ? locked_idx_q : rr_sel;
  assign issue = rst_ni && master_req_i[sel].req && !fifo_full;
  assign grant = issue && slave_resp_i.gnt;
  assign pop   = slave_resp_i.rvalid && !fifo_empty;

  always_comb begin
    slave_req_o     = master_req_i[sel];
    slave_req_o.req = issue;
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    if (grant) begin
      lock_d   = 1'b0;
      rr_ptr_d = (sel == IdxW'(NumMasters - 1)) ? '0 : sel + 1'b1;
    end else if (issue) begin
      lock_d       = 1'b1;
      locked_idx_d = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
    end
  end

  periph_arb_idx_fifo #(
    .Depth (MaxOutstanding),
    .Width (IdxW)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (grant),
    .data_i  (sel),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (outstanding_o)
  );

  for (genvar gi = 0; gi < NumMasters; gi++) begin : g_resp
    logic route_rsp;
    assign route_rsp         = pop && (fifo_head == IdxW'(gi));
    assign master_resp_o[gi] = '{gnt:    grant && (sel == IdxW'(gi)),
                                 rvalid: route_rsp,
                                 rdata:  route_rsp ? slave_resp_i.rdata : 32'h0};
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && slave_resp_i.rvalid) begin
      assert (!fifo_empty)
        else $warning("periph_obi_arbiter: rvalid with nothing outstanding, response dropped");
    end
  end
`endif

endmodule
